chia_xung_tham_so: RTL and testbench



---
 rtl/chia_xung_pkg.sv | 26 ++
 rtl/chia_xung_tham_so.sv | 89 ++++++++
 tb/tb_chia_xung_tham_so.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/chia_xung_pkg.sv
// Shared constants for the parametrised 50 MHz clock divider: mode encoding,
// default half-periods and the counter-width helper.
package chia_xung_pkg;

  localparam logic [1:0] MODE_1HZ  = 2'd0;
  localparam logic [1:0] MODE_2HZ  = 2'd1;
  localparam logic [1:0] MODE_10HZ = 2'd2;
  localparam logic [1:0] MODE_1KHZ = 2'd3;

  // Half-periods in 50 MHz input cycles
  localparam int unsigned HALF_1HZ  = 25_000_000;
  localparam int unsigned HALF_2HZ  = 12_500_000;
  localparam int unsigned HALF_10HZ = 2_500_000;
  localparam int unsigned HALF_1KHZ = 25_000;

  function automatic int unsigned max_half(input int unsigned h0, input int unsigned h1,
                                           input int unsigned h2, input int unsigned h3);
    int unsigned m;
    m = h0;
    if (h1 > m) m = h1;
    if (h2 > m) m = h2;
    if (h3 > m) m = h3;
    return m;
  endfunction

endpackage

// File: rtl/chia_xung_tham_so.sv
// 50 % duty clock divider with four run-time half-period presets, count enable and
// mode switching applied only at phase boundaries. Optional Tick output: TICK_OUT_EN.
module chia_xung_tham_so
  import chia_xung_pkg::*;
#(
  parameter int          CNT_W = 25,
  parameter int unsigned HALF0 = HALF_1HZ,
  parameter int unsigned HALF1 = HALF_2HZ,
  parameter int unsigned HALF2 = HALF_10HZ,
  parameter int unsigned HALF3 = HALF_1KHZ
) (
  input  logic       Clk50MHz,
  input  logic       Rst,
  input  logic       En,
  input  logic [1:0] Mode,
  output logic       Clk,
  output logic [1:0] ModeAct,
  output logic       ModeChg
`ifdef TICK_OUT_EN
  ,
  output logic       Tick
`endif
);

  // Reject unusable configurations at elaboration
  if (HALF0 == 0 || HALF1 == 0 || HALF2 == 0 || HALF3 == 0) begin : g_bad_half
    $error("chia_xung_tham_so: every HALFn must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 32 ||
      64'(max_half(HALF0, HALF1, HALF2, HALF3)) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("chia_xung_tham_so: CNT_W too narrow for the largest half-period");
  end

  localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             at_term;

  // Terminal count follows the applied mode, never the requested one
  always_comb begin
    term = TERM0;
    case (ModeAct)
      MODE_1HZ:  term = TERM0;
      MODE_2HZ:  term = TERM1;
      MODE_10HZ: term = TERM2;
      MODE_1KHZ: term = TERM3;
      default:   term = TERM0;
    endcase
  end

  assign at_term = (cnt >= term);

  always_ff @(posedge Clk50MHz) begin
    if (Rst) begin
      cnt     <= '0;
      Clk     <= 1'b0;
      ModeAct <= Mode;
      ModeChg <= 1'b0;
    end else begin
      ModeChg <= 1'b0;
      if (En) begin
        if (at_term) begin
          // Phase boundary: the only point where a new mode may take effect
          cnt <= '0;
          Clk <= ~Clk;
          if (Mode != ModeAct) begin
            ModeAct <= Mode;
            ModeChg <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef TICK_OUT_EN
  // Same-domain clock enable marking each rising edge of Clk
  always_ff @(posedge Clk50MHz) begin
    if (Rst) Tick <= 1'b0;
    else     Tick <= En && at_term && !Clk;
  end
`endif

endmodule

// File: tb/tb_chia_xung_tham_so.sv
// Self-checking bench for chia_xung_tham_so with small half-periods (2,3,5,1).
module tb_chia_xung_tham_so;
  localparam int CNT_W = 4;
  localparam int H0 = 2, H1 = 3, H2 = 5, H3 = 1;

  logic       clk50 = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b1;
  logic [1:0] mode  = 2'd1;
  logic       dclk;
  logic [1:0] mode_act;
  logic       mode_chg;
`ifdef TICK_OUT_EN
  logic       tick;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  chia_xung_tham_so #(.CNT_W(CNT_W), .HALF0(H0), .HALF1(H1), .HALF2(H2), .HALF3(H3)) dut (
    .Clk50MHz(clk50),
    .Rst     (rst),
    .En      (en),
    .Mode    (mode),
    .Clk     (dclk),
    .ModeAct (mode_act),
    .ModeChg (mode_chg)
`ifdef TICK_OUT_EN
    ,
    .Tick    (tick)
`endif
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles left in the current phase, counted down; phase length looked up per mode
  int   half_tab [4] = '{H0, H1, H2, H3};
  int   m_left;
  bit   m_clk, m_chg, m_tick, m_valid;
  logic [1:0] m_mode;

  always @(posedge clk50) begin
    if (rst) begin
      m_clk = 0; m_mode = mode; m_left = half_tab[mode]; m_chg = 0; m_tick = 0; m_valid = 1;
    end else begin
      m_chg = 0; m_tick = 0;
      if (en) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_clk  = !m_clk;
          m_tick = m_clk;
          if (mode != m_mode) begin m_mode = mode; m_chg = 1; end
          m_left = half_tab[m_mode];
        end
      end
    end
  end

  always @(negedge clk50) begin
    if (m_valid) begin
      chk("model_clk", {31'd0, dclk}, {31'd0, m_clk});
      chk("model_mode_act", {30'd0, mode_act}, {30'd0, m_mode});
      chk("model_mode_chg", {31'd0, mode_chg}, {31'd0, m_chg});
`ifdef TICK_OUT_EN
      chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk50);
  endtask

  initial begin
    // reset with Mode=1
    step(2);
    chk("rst_clk", {31'd0, dclk}, 32'd0);
    chk("rst_mode_act", {30'd0, mode_act}, 32'd1);
    chk("rst_chg", {31'd0, mode_chg}, 32'd0);
    rst = 1'b0;
    step(2);
    chk("m1_low_hold", {31'd0, dclk}, 32'd0);
    step(1);
    chk("m1_first_rise", {31'd0, dclk}, 32'd1);
    // change to mode 0 mid-phase (cnt=1): phase keeps its 3 cycles
    step(1);
    mode = 2'd0;
    step(1);
    chk("m1_phase_intact", {31'd0, dclk}, 32'd1);
    chk("m1_no_early_chg", {30'd0, mode_act}, 32'd1);
    step(1);
    chk("chg_clk_fall", {31'd0, dclk}, 32'd0);
    chk("chg_mode_act", {30'd0, mode_act}, 32'd0);
    chk("chg_pulse", {31'd0, mode_chg}, 32'd1);
    step(1);
    chk("chg_pulse_end", {31'd0, mode_chg}, 32'd0);
    step(1);
    chk("m0_rise", {31'd0, dclk}, 32'd1);
    // 0->2->0 within one phase: no change registered
    mode = 2'd2;
    step(1);
    mode = 2'd0;
    step(1);
    chk("glitch_clk", {31'd0, dclk}, 32'd0);
    chk("glitch_no_chg", {31'd0, mode_chg}, 32'd0);
    chk("glitch_mode_act", {30'd0, mode_act}, 32'd0);
    // mode 3: toggle every enabled edge
    mode = 2'd3;
    step(2);
    chk("m3_enter", {30'd0, mode_act}, 32'd3);
    chk("m3_clk", {31'd0, dclk}, 32'd1);
    step(1);
    chk("m3_toggle", {31'd0, dclk}, 32'd0);
    en = 1'b0;
    step(5);
    chk("m3_frozen", {31'd0, dclk}, 32'd0);
    en = 1'b1;
    step(1);
    chk("m3_resume", {31'd0, dclk}, 32'd1);
    // mode 2, freeze mid-phase then finish remaining count
    mode = 2'd2;
    step(1);
    chk("m2_enter", {30'd0, mode_act}, 32'd2);
    chk("m2_clk_low", {31'd0, dclk}, 32'd0);
    step(2);
    en = 1'b0;
    step(5);
    chk("m2_frozen", {31'd0, dclk}, 32'd0);
    en = 1'b1;
    step(2);
    chk("m2_before_rise", {31'd0, dclk}, 32'd0);
    step(1);
    chk("m2_rise", {31'd0, dclk}, 32'd1);
    step(3);
    // reset at cnt=3 in mode 2
    rst = 1'b1;
    step(1);
    chk("rst2_clk", {31'd0, dclk}, 32'd0);
    chk("rst2_mode_act", {30'd0, mode_act}, 32'd2);
    rst = 1'b0;
    step(4);
    chk("rst2_full_low", {31'd0, dclk}, 32'd0);
    step(1);
    chk("rst2_rise", {31'd0, dclk}, 32'd1);
`ifdef TICK_OUT_EN
    chk("tick_at_rise", {31'd0, tick}, 32'd1);
    step(1);
    chk("tick_one_cycle", {31'd0, tick}, 32'd0);
`endif
    // mode 0 tail run for the model check
    mode = 2'd0;
    step(12);
    chk("tail_mode_act", {30'd0, mode_act}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
